// File: rtl/sliding_window_3x3_pkg.sv
// Purpose: shared pixel/window types for the 3x3 window front end and the filter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package swin_pkg;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Element k-1 holds sw_pixels<k>: 0 is top-left, 4 the centre, 8 bottom-right.
  typedef pixel_t [8:0] window_t;
endpackage

// File: rtl/sliding_window_3x3_if.sv
// Purpose: raster pixel input and 3x3 window output bundle of sliding_window_3x3.
// Latency: n/a (wiring only).
// Backpressure: none; every in_valid beat is consumed.
// Ports: in_valid/in_sof/in_pixel from the source, sw_pixels1..9/act/frame_done to the filter.
//   master = pixel source / window consumer side, slave = the window generator.
interface sliding_window_3x3_if;
  import swin_pkg::*;

  logic   in_valid;
  logic   in_sof;
  pixel_t in_pixel;
  pixel_t sw_pixels1, sw_pixels2, sw_pixels3;
  pixel_t sw_pixels4, sw_pixels5, sw_pixels6;
  pixel_t sw_pixels7, sw_pixels8, sw_pixels9;
  logic   act;
  logic   frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  sw_pixels1, sw_pixels2, sw_pixels3,
    input  sw_pixels4, sw_pixels5, sw_pixels6,
    input  sw_pixels7, sw_pixels8, sw_pixels9,
    input  act, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output sw_pixels1, sw_pixels2, sw_pixels3,
    output sw_pixels4, sw_pixels5, sw_pixels6,
    output sw_pixels7, sw_pixels8, sw_pixels9,
    output act, frame_done
  );
endinterface

// File: rtl/sliding_window_3x3_line_buffer.sv
// Purpose: one image line of pixels, single port, read-before-write.
// Latency: read is combinational from addr; write lands on the rising edge.
// Backpressure: none; a write happens on every cycle with we high.
// Ports: clk, we (write strobe), addr (column), wdata (new pixel), rdata (old pixel at addr).
module line_buffer
  import swin_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  // Contents are intentionally not reset: the first two lines of every
  // frame overwrite whatever is here before a window can use it.
  pixel_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/sliding_window_3x3.sv
// Purpose: raster pixel stream to 3x3 neighbourhood windows for interior centres.
// Latency: window completed by the accept at edge N is on the buses after edge N (act=1 one cycle).
// Backpressure: none; every in_valid beat is consumed, outputs hold between accepts.
// Ports: clk, rst (sync, active-high), s = slave side of sliding_window_3x3_if.
module sliding_window_3x3
  import swin_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input logic                 clk,
  input logic                 rst,
  sliding_window_3x3_if.slave s
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          accept;
  pixel_t        lb0_rd, lb1_rd;
  window_t       win;
  logic          act_q, frame_done_q;

  // in_sof forces the accepted pixel to (0,0) whatever the counters say.
  assign cur_col = s.in_sof ? '0 : col;
  assign cur_row = s.in_sof ? '0 : row;
  // A pixel arriving together with reset is dropped, including its buffer write.
  assign accept  = s.in_valid && !rst;

  // lb0 holds line r-1, lb1 holds line r-2; lb1 is fed from lb0's old word.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (s.in_pixel),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      act_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      act_q        <= s.in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done_q <= s.in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (s.in_valid) begin
        // Shift every row left; the right column takes the two old line
        // words and the incoming pixel.
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= lb1_rd;
        win[5] <= lb0_rd;
        win[8] <= s.in_pixel;

        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  assign s.sw_pixels1 = win[0];
  assign s.sw_pixels2 = win[1];
  assign s.sw_pixels3 = win[2];
  assign s.sw_pixels4 = win[3];
  assign s.sw_pixels5 = win[4];
  assign s.sw_pixels6 = win[5];
  assign s.sw_pixels7 = win[6];
  assign s.sw_pixels8 = win[7];
  assign s.sw_pixels9 = win[8];
  assign s.act        = act_q;
  assign s.frame_done = frame_done_q;
endmodule

// File: tb/tb_sliding_window_3x3.sv
// Purpose: scoreboard bench for sliding_window_3x3 on 4x4, 5x5 and 3x3 instances.
// Latency: expects each window one cycle after its completing accept.
// Backpressure: none exercised; the DUT has none.
module tb_sliding_window_3x3;
  import swin_pkg::*;

  typedef struct packed {
    logic [71:0] win;
    logic        fd;
    logic [31:0] cyc;
  } exp_t;

  localparam int WD [3] = '{4, 5, 3};
  localparam int HD [3] = '{4, 5, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pix = 8'h00;

  always #5 clk = ~clk;

  sliding_window_3x3_if if0 ();
  sliding_window_3x3_if if1 ();
  sliding_window_3x3_if if2 ();

  assign if0.in_valid = valid;  assign if0.in_sof = sof;  assign if0.in_pixel = pix;
  assign if1.in_valid = valid;  assign if1.in_sof = sof;  assign if1.in_pixel = pix;
  assign if2.in_valid = valid;  assign if2.in_sof = sof;  assign if2.in_pixel = pix;

  sliding_window_3x3 #(.IMG_W(4), .IMG_H(4)) dut0 (.clk(clk), .rst(rst), .s(if0));
  sliding_window_3x3 #(.IMG_W(5), .IMG_H(5)) dut1 (.clk(clk), .rst(rst), .s(if1));
  sliding_window_3x3 #(.IMG_W(3), .IMG_H(3)) dut2 (.clk(clk), .rst(rst), .s(if2));

  logic [71:0] o_win [3];
  logic        o_act [3];
  logic        o_fd  [3];

  assign o_win[0] = {if0.sw_pixels1, if0.sw_pixels2, if0.sw_pixels3, if0.sw_pixels4,
                     if0.sw_pixels5, if0.sw_pixels6, if0.sw_pixels7, if0.sw_pixels8, if0.sw_pixels9};
  assign o_win[1] = {if1.sw_pixels1, if1.sw_pixels2, if1.sw_pixels3, if1.sw_pixels4,
                     if1.sw_pixels5, if1.sw_pixels6, if1.sw_pixels7, if1.sw_pixels8, if1.sw_pixels9};
  assign o_win[2] = {if2.sw_pixels1, if2.sw_pixels2, if2.sw_pixels3, if2.sw_pixels4,
                     if2.sw_pixels5, if2.sw_pixels6, if2.sw_pixels7, if2.sw_pixels8, if2.sw_pixels9};
  assign o_act[0] = if0.act;  assign o_fd[0] = if0.frame_done;
  assign o_act[1] = if1.act;  assign o_fd[1] = if1.frame_done;
  assign o_act[2] = if2.act;  assign o_fd[2] = if2.frame_done;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        rst_prev = 1'b0;
  logic        acc_prev = 1'b0;
  logic [7:0]  img [3][5][5];
  int          r_pos [3];
  int          c_pos [3];
  int          m_rr, m_cc;
  exp_t        m_e, mon_e;
  exp_t        exp_q [3][$];
  int          act_cnt [3];
  logic [71:0] first_win [3], fifth_win [3], last_win [3], hold_win [3];
  logic        last_fd [3];
  logic        hold_ok [3];

  task automatic chk(input string nm, input int d, input logic [71:0] got, input logic [71:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, d, got, want);
    end
  endtask

  // Window whose top-left pixel is (r0,c0) of a 16r+c frame.
  function automatic logic [71:0] cwin(input int r0, input int c0);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (3*i + j))*8 +: 8] = 8'(16*(r0 + i) + c0 + j);
    return w;
  endfunction

  // Window centred one up/left of (rr,cc), taken from the model image.
  function automatic logic [71:0] mkwin(input int d, input int rr, input int cc);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (3*i + j))*8 +: 8] = img[d][rr-2+i][cc-2+j];
    return w;
  endfunction

  // Reference model: track raster position, store the frame, emit windows.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        r_pos[d] = 0;
        c_pos[d] = 0;
      end else if (valid) begin
        m_rr = sof ? 0 : r_pos[d];
        m_cc = sof ? 0 : c_pos[d];
        img[d][m_rr][m_cc] = pix;
        if (m_rr >= 2 && m_cc >= 2) begin
          m_e.win = mkwin(d, m_rr, m_cc);
          m_e.fd  = (m_rr == HD[d] - 1) && (m_cc == WD[d] - 1);
          m_e.cyc = 32'(cyc);
          exp_q[d].push_back(m_e);
        end
        if (m_cc == WD[d] - 1) begin
          c_pos[d] = 0;
          r_pos[d] = (m_rr == HD[d] - 1) ? 0 : m_rr + 1;
        end else begin
          c_pos[d] = m_cc + 1;
          r_pos[d] = m_rr;
        end
      end
    end
    rst_prev = rst;
    acc_prev = valid && !rst;
  end

  // Monitor: compare on the falling edge, between DUT updates.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_prev) begin
        chk("reset_window", d, o_win[d], '0);
        chk("reset_flags", d, {o_act[d], o_fd[d]}, '0);
        hold_ok[d] = 1'b0;
      end else if (o_act[d]) begin
        if (exp_q[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_act dut%0d: got act=1 window %h, want act=0", d, o_win[d]);
        end else begin
          mon_e = exp_q[d].pop_front();
          chk("window", d, o_win[d], mon_e.win);
          chk("frame_done", d, o_fd[d], mon_e.fd);
          chk("act_timing", d, cyc, mon_e.cyc);
          act_cnt[d]++;
          if (act_cnt[d] == 1) first_win[d] = o_win[d];
          if (act_cnt[d] == 5) fifth_win[d] = o_win[d];
          last_win[d] = o_win[d];
          last_fd[d]  = o_fd[d];
          hold_win[d] = mon_e.win;
          hold_ok[d]  = 1'b1;
        end
      end else begin
        if (exp_q[d].size() > 0 && exp_q[d][0].cyc == 32'(cyc)) begin
          mon_e = exp_q[d].pop_front();
          chk("missing_act", d, o_act[d], 1'b1);
        end
        chk("fd_without_act", d, o_fd[d], 1'b0);
        if (acc_prev) hold_ok[d] = 1'b0;
        else if (hold_ok[d]) chk("hold_window", d, o_win[d], hold_win[d]);
      end
    end
  end

  task automatic beat(input logic v, input logic s, input logic [7:0] p, input logic r = 1'b0);
    valid = v;
    sof   = s;
    pix   = p;
    rst   = r;
    @(posedge clk);
    #1;
    rst   = 1'b0;
  endtask

  task automatic start_test();
    beat(1'($urandom), 1'b0, 8'($urandom), 1'b1);
    for (int d = 0; d < 3; d++) act_cnt[d] = 0;
  endtask

  task automatic idle_drain();
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 8'($urandom));
    for (int d = 0; d < 3; d++) chk("drained", d, exp_q[d].size(), 0);
  endtask

  task automatic send_frame(input int w, input int h, input bit gaps, input bit with_sof);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        beat(1'b1, with_sof && r == 0 && c == 0, 8'(16*r + c));
        // Gap beats carry sof=1 to show it is ignored without valid.
        if (gaps) beat(1'b0, 1'b1, 8'($urandom));
      end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      act_cnt[d] = 0;
      hold_ok[d] = 1'b0;
      last_fd[d] = 1'b0;
    end
    #1;
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // 1: 4x4 continuous
    start_test();
    send_frame(4, 4, 1'b0, 1'b1);
    idle_drain();
    chk("t1_count", 0, act_cnt[0], 4);
    chk("t1_first", 0, first_win[0], cwin(0, 0));
    chk("t1_last_sw5", 0, last_win[0][39:32], 8'h22);
    chk("t1_last_sw9", 0, last_win[0][7:0], 8'h33);
    chk("t1_last_fd", 0, last_fd[0], 1'b1);

    // 2: 4x4 with valid toggling
    start_test();
    send_frame(4, 4, 1'b1, 1'b1);
    idle_drain();
    chk("t2_count", 0, act_cnt[0], 4);
    chk("t2_first", 0, first_win[0], cwin(0, 0));
    chk("t2_last", 0, last_win[0], cwin(1, 1));

    // 3: two back-to-back 4x4 frames
    start_test();
    send_frame(4, 4, 1'b0, 1'b1);
    send_frame(4, 4, 1'b0, 1'b1);
    idle_drain();
    chk("t3_count", 0, act_cnt[0], 8);
    chk("t3_fifth", 0, fifth_win[0], cwin(0, 0));
    chk("t3_last", 0, last_win[0], cwin(1, 1));

    // 4: 5x5, sof reasserted at (2,1)
    start_test();
    for (int i = 0; i < 11; i++) beat(1'b1, i == 0, 8'hEE);
    send_frame(5, 5, 1'b0, 1'b1);
    idle_drain();
    chk("t4_count", 1, act_cnt[1], 9);
    chk("t4_first", 1, first_win[1], cwin(0, 0));
    chk("t4_last", 1, last_win[1], cwin(2, 2));

    // 5: 5x5, reset at (3,2) with a valid pixel, then a full frame without sof
    start_test();
    for (int i = 0; i < 17; i++) beat(1'b1, i == 0, 8'(16*(i/5) + (i%5)));
    beat(1'b1, 1'b0, 8'h32, 1'b1);
    send_frame(5, 5, 1'b0, 1'b0);
    idle_drain();
    chk("t5_count", 1, act_cnt[1], 12);
    chk("t5_last", 1, last_win[1], cwin(2, 2));
    chk("t5_last_fd", 1, last_fd[1], 1'b1);

    // 6: 3x3 single window
    start_test();
    send_frame(3, 3, 1'b0, 1'b1);
    idle_drain();
    chk("t6_count", 2, act_cnt[2], 1);
    chk("t6_window", 2, first_win[2], cwin(0, 0));
    chk("t6_fd", 2, last_fd[2], 1'b1);

    // 7: random valid, pixels, sof and reset
    start_test();
    for (int i = 0; i < 3000; i++)
      beat(($urandom % 4) != 0, ($urandom % 150) == 0, 8'($urandom), ($urandom % 400) == 0);
    idle_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sliding_window_3x3.md
# sliding_window_3x3

Raster-to-window front end for the 3×3 neighbourhood filter. It accepts one 8-bit pixel per cycle in row-major raster order and stores the two previous image lines. For every interior pixel centre it emits a full 3×3 window on nine parallel 8-bit buses, together with a one-cycle `act` strobe. It sits directly upstream of `filter` and drives that block's `sw_pixels1..9` and `act` inputs.

## Interface
- `IMG_W`, default 256: pixels per line; legal range 3..4096.
- `IMG_H`, default 256: lines per frame; legal range 3..4096.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst` input, 1 bit: one clock; reset is synchronous and active-high.
- `in_valid` input, 1 bit: `in_pixel` is accepted on this edge. There is no backpressure; every valid beat is consumed.
- `in_sof` input, 1 bit: start of frame. It is qualified by `in_valid`. It marks the accepted pixel as (row 0, col 0).
- `in_pixel` input, 8 bits: raster pixel.
- `sw_pixels1` … `sw_pixels9` output, 8 bits each: window in row-major order. 1 is top-left, 5 is the centre, 9 is bottom-right.
- `act` output, 1 bit: the window buses hold a new valid window this cycle.
- `frame_done` output, 1 bit: one-cycle pulse coincident with the last window of a frame.

## Operation
- Counters:
  - `col` runs 0..IMG_W-1 and advances on each accepted pixel.
  - At IMG_W-1, `col` wraps to 0 and `row` advances.
  - `row` runs 0..IMG_H-1 and wraps to 0 after the last pixel of the frame.
- Line buffers: `lb0` holds line r-1 and `lb1` holds line r-2. Each is IMG_W×8 and addressed by `col`. They are read-before-write. On each accept:
  - `lb1[col] <= lb0[col]`
  - `lb0[col] <= in_pixel`
- Window registers: three rows of three 8-bit registers. On each accept every row shifts left by one column, and the new right column loads as follows:
  - top row takes the old `lb1[col]`;
  - middle row takes the old `lb0[col]`;
  - bottom row takes `in_pixel`.
- Window validity:
  - `act` is registered: `act <= in_valid && row >= 2 && col >= 2`.
  - The window centre is (row-1, col-1).
  - A frame therefore yields exactly (IMG_W-2)·(IMG_H-2) windows. Border centres are not emitted.
- `frame_done` is registered as the accept of the pixel at (IMG_H-1, IMG_W-1).
- With `in_sof` high, the accepted pixel is treated as (0,0) regardless of the counters, and counting resumes from there.
  - A mid-frame `in_sof` abandons the partial frame.
  - Stale line-buffer data is never emitted, because rows 0 and 1 overwrite it before `act` can assert.
- When `in_valid` is low, all state holds and `act` is 0.
  - Windows never span a wrap: the shift registers refill through cols 0 and 1 before `act` can assert.
- Arithmetic: the block performs no pixel arithmetic; values pass through unmodified.

## Timing
- Latency: a window completed by the pixel accepted at edge N appears on `sw_pixels1..9` with `act=1` in the cycle after edge N.
  - The buses hold that window until the next accept.
  - `act` is high for exactly one cycle per window.
- Throughput: one window per accepted pixel in the interior, with zero bubbles at `in_valid`=1 continuous.
- At line and frame wraps `act` is 0 for 2 cycles (cols 0 and 1) and for rows 0 and 1.
- Reset, applied at any time, including mid-frame:
  - `row` and `col` go to 0.
  - `act` and `frame_done` go to 0.
  - All nine window buses go to 0.
  - Line-buffer contents are not cleared.
  - The first pixel after reset is treated as (0,0) even without `in_sof`.
- Reset and `in_valid` in the same cycle: reset wins and the pixel is dropped.
- `in_sof` with `in_valid`=0 is ignored.

## Structure
- Shared package `swin_pkg`:
  - `PIX_W` = 8;
  - `pixel_t` (logic [7:0]);
  - `window_t`, an array of nine `pixel_t`, shared with the filter side.
- Counter width is $clog2(IMG_W) / $clog2(IMG_H), declared locally.
- One sub-module, `line_buffer`: single-port, read-before-write, DEPTH = IMG_W, 8-bit. Instantiate it twice.
  - Its read data is combinational from the registered address path so that the new right column lands in the same edge.
  - Alternatively it may be an inferred array with a combinational read.
- Everything else (counters, window shift registers, flags) lives in the top module.

## Test plan
Pixel value = 16·r + c throughout.
1. IMG_W=IMG_H=4, continuous valid, pixels 16r+c. Expect exactly 4 `act` pulses. The first, one cycle after pixel 0x22 is accepted, has:
   - sw1..3 = 00,01,02
   - sw4..6 = 10,11,12
   - sw7..9 = 20,21,22
   The last pulse has sw5 = 0x22, sw9 = 0x33, and `frame_done`=1.
2. Same frame with `in_valid` toggling every other cycle. Expect identical window contents and count. `act` follows each qualifying accept by 1 cycle, and the buses stay stable during gaps.
3. Two back-to-back 4×4 frames with no idle cycles. Expect 8 windows. The fifth window equals the first. `act` is 0 during rows 0–1 of frame 2.
4. `in_sof` reasserted at (2,1) of a 5×5 frame. Expect no `act` until the new frame's pixel (2,2). The subsequent windows contain only new-frame data.
5. `rst` pulsed at (3,2) of a 5×5 frame. Expect all outputs to read 0 the next cycle. The next pixel is treated as (0,0); with a full 5×5 frame it yields 9 correct windows.
6. IMG_W=3, IMG_H=3. Expect exactly one `act`, with `frame_done` after pixel 0x22, and sw1..9 = 00,01,02,10,11,12,20,21,22.
